// File: rtl/test_pattern_gen.sv
// rtl/test_pattern_gen.sv - Video test pattern generator with fv/lv frame timing
// Four selectable patterns, PPC pixels per beat, all outputs registered from next-state.
module test_pattern_gen #(
    parameter int DATA_WIDTH    = 10,
    parameter int PPC           = 1,
    parameter int H_ACTIVE      = 30,
    parameter int V_ACTIVE      = 40,
    parameter int H_BLANK       = 16,
    parameter int V_BLANK_LINES = 25,
    parameter int FV_LEAD       = 4,
    parameter int FV_TRAIL      = 4
) (
    input  logic                      pixel_clk,
    input  logic                      pixel_rst_n,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [DATA_WIDTH-1:0]     solid_value,
    output logic                      fv,
    output logic                      lv,
    output logic [DATA_WIDTH*PPC-1:0] data,
    output logic [15:0]               frame_cnt,
    output logic                      busy
);
    localparam int BEATS      = H_ACTIVE / PPC;
    localparam int VBL_CYCLES = V_BLANK_LINES * (BEATS + H_BLANK);
    localparam int BAR_W      = H_ACTIVE / 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(max2(FV_LEAD, FV_TRAIL), max2(BEATS, H_BLANK)), VBL_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(V_ACTIVE + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FV_LEAD,
        ST_ACTIVE,
        ST_HBLANK,
        ST_FV_TRAIL,
        ST_VBLANK
    } state_t;

    state_t                   state_q, state_n;
    logic [CW-1:0]            cnt_q, cnt_n;
    logic [RW-1:0]            row_q, row_n;
    logic [15:0]              frame_cnt_n;
    logic [15:0]              frame_base_q;
    logic [1:0]               mode_q;
    logic [DATA_WIDTH-1:0]    solid_q;
    logic                     latch_frame;
    logic                     frame_done;
    logic [DATA_WIDTH*PPC-1:0] data_n;

    function automatic logic [DATA_WIDTH-1:0] pixel(input logic [1:0] m, input int c, input int r,
                                                    input int fb, input logic [DATA_WIDTH-1:0] s);
        int bar;
        bar = c / BAR_W;
        if (bar > 7) bar = 7;
        case (m)
            2'd0:    pixel = DATA_WIDTH'(bar) << (DATA_WIDTH - 3);
            2'd1:    pixel = DATA_WIDTH'(c);
            2'd2:    pixel = DATA_WIDTH'(c + r + fb);
            default: pixel = s;
        endcase
    endfunction

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q + CW'(1);
        row_n       = row_q;
        latch_frame = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    state_n     = ST_FV_LEAD;
                    latch_frame = 1'b1;
                end
            end
            ST_FV_LEAD: begin
                if (cnt_q == CW'(FV_LEAD - 1)) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = '0;
                    row_n   = '0;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == CW'(BEATS - 1)) begin
                    cnt_n = '0;
                    if (row_q == RW'(V_ACTIVE - 1)) begin
                        state_n = ST_FV_TRAIL;
                    end else begin
                        state_n = ST_HBLANK;
                        row_n   = row_q + RW'(1);
                    end
                end
            end
            ST_HBLANK: begin
                if (cnt_q == CW'(H_BLANK - 1)) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = '0;
                end
            end
            ST_FV_TRAIL: begin
                if (cnt_q == CW'(FV_TRAIL - 1)) begin
                    cnt_n      = '0;
                    frame_done = 1'b1;
                    if (!enable) begin
                        state_n = ST_IDLE;
                    end else if (VBL_CYCLES == 0) begin
                        state_n     = ST_FV_LEAD;
                        latch_frame = 1'b1;
                    end else begin
                        state_n = ST_VBLANK;
                    end
                end
            end
            ST_VBLANK: begin
                if (cnt_q == CW'(VBL_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (enable) begin
                        state_n     = ST_FV_LEAD;
                        latch_frame = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign frame_cnt_n = frame_cnt + {15'd0, frame_done};

    // Data is built from next-state counters so it lines up with the registered lv.
    always_comb begin
        data_n = '0;
        if (state_n == ST_ACTIVE) begin
            for (int k = 0; k < PPC; k++) begin
                data_n[k*DATA_WIDTH +: DATA_WIDTH] =
                    pixel(mode_q, int'(cnt_n) * PPC + k, int'(row_n), int'(frame_base_q), solid_q);
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            frame_cnt    <= '0;
            frame_base_q <= '0;
            mode_q       <= '0;
            solid_q      <= '0;
            fv           <= 1'b0;
            lv           <= 1'b0;
            data         <= '0;
            busy         <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            row_q     <= row_n;
            frame_cnt <= frame_cnt_n;
            // Frame base includes a count bump made on this same edge.
            if (latch_frame) begin
                mode_q       <= mode;
                solid_q      <= solid_value;
                frame_base_q <= frame_cnt_n;
            end
            fv   <= (state_n == ST_FV_LEAD) || (state_n == ST_ACTIVE) ||
                    (state_n == ST_HBLANK)  || (state_n == ST_FV_TRAIL);
            lv   <= (state_n == ST_ACTIVE);
            data <= data_n;
            busy <= (state_n != ST_IDLE);
        end
    end
endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 10: bits per pixel; legal range 3 to 16.
REQ-002 Parameter PPC, default 1: pixels per clock beat; legal values 1, 2, 4.
REQ-003 Parameter H_ACTIVE, default 30: active pixels per line; must be a multiple of PPC and at least 8.
REQ-004 Parameter V_ACTIVE, default 40: active lines per frame; at least 1.
REQ-005 Parameter H_BLANK, default 16: cycles with lv low between lines; at least 1.
REQ-006 Parameter V_BLANK_LINES, default 25: line periods with fv low between frames.
REQ-007 Parameter FV_LEAD, default 4: cycles from fv rise to first lv rise; at least 1.
REQ-008 Parameter FV_TRAIL, default 4: cycles from last lv fall to fv fall; at least 1.
REQ-009 pixel_clk  input  1  Sole clock; all logic on its rising edge.
REQ-010 pixel_rst_n  input  1  Reset; asynchronous, active-low.
REQ-011 enable  input  1  Start/continue frame generation.
REQ-012 mode  input  2  Pattern select: 0 colorbar, 1 horizontal ramp, 2 moving ramp, 3 solid.
REQ-013 solid_value  input  DATA_WIDTH  Pixel value for mode 3.
REQ-014 fv  output  1  Frame valid.
REQ-015 lv  output  1  Line valid.
REQ-016 data  output  DATA_WIDTH*PPC  Pixel beat; lane k holds column col+k, lane 0 in LSBs.
REQ-017 frame_cnt  output  16  Completed-frame counter.
REQ-018 busy  output  1  High in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, FV_LEAD, ACTIVE, HBLANK, FV_TRAIL, VBLANK; all outputs SHALL be registered.
REQ-020 IDLE -> FV_LEAD when enable is sampled high; fv SHALL rise one cycle after that sample.
REQ-021 FV_LEAD SHALL last FV_LEAD cycles with fv=1 and lv=0, then go to ACTIVE.
REQ-022 ACTIVE SHALL last H_ACTIVE/PPC cycles with fv=1 and lv=1; afterwards go to HBLANK if lines remain, else FV_TRAIL.
REQ-023 HBLANK SHALL last H_BLANK cycles with fv=1 and lv=0, then go to ACTIVE; HBLANK never follows the last line.
REQ-024 FV_TRAIL SHALL last FV_TRAIL cycles with fv=1 and lv=0; on exit frame_cnt increments (wraps 0xFFFF->0), then go to VBLANK if enable=1, else IDLE.
REQ-025 VBLANK SHALL last V_BLANK_LINES*(H_ACTIVE/PPC+H_BLANK) cycles with fv=0; zero length skips straight to FV_LEAD; exit goes to FV_LEAD if enable=1, else IDLE.
REQ-026 Deasserting enable mid-frame SHALL NOT truncate the frame; it only takes effect at FV_TRAIL or VBLANK exit.
REQ-027 mode and solid_value SHALL be latched on entry to FV_LEAD and held constant for the whole frame.
REQ-028 data SHALL be 0 whenever lv=0.
REQ-029 Column col counts 0..H_ACTIVE-1 in steps of PPC within a line; row counts 0..V_ACTIVE-1 within a frame.
REQ-030 Mode 0 pixel: bar = min(c/(H_ACTIVE/8), 7), where c is the pixel column; value = bar in the top 3 bits, zeros below.
REQ-031 Mode 1 pixel = c mod 2^DATA_WIDTH.
REQ-032 Mode 2 pixel = (c + row + frame_cnt) mod 2^DATA_WIDTH, using frame_cnt as latched at frame start.
REQ-033 Mode 3 pixel = latched solid_value on every lane.
REQ-034 Frame timing SHALL have no dependence on mode.

Reset
REQ-035 pixel_rst_n low SHALL immediately force IDLE, fv=0, lv=0, data=0, frame_cnt=0, busy=0 and clear all counters, including mid-line.
REQ-036 After reset release, generation SHALL start only on a new enable=1 sample.

Verification
REQ-037 Defaults; enable held 1, mode 0 -> fv high 1832 cycles, 40 lv pulses of 30 cycles, 16-cycle gaps, fv low 1150 cycles between frames.
REQ-038 Mode 0 defaults -> cols 0-2 = 0x000, cols 3-5 = 0x080, cols 21-29 = 0x380.
REQ-039 Mode 2, PPC=2, frame_cnt=5, row 3, beat col=10 -> data = {0x013, 0x012}.
REQ-040 enable dropped at row 10 -> frame completes all 40 lines, frame_cnt+1, then busy=0, fv stays 0.
REQ-041 mode changed 1->3 mid-frame -> current frame stays ramp; next frame is all solid_value.
REQ-042 pixel_rst_n pulsed low during ACTIVE -> fv, lv, data, frame_cnt all 0 asynchronously; no output activity until enable is re-sampled.
